// File: rtl/apb_initiator.sv
// Single-outstanding APB4 initiator: turns core req/gnt/rvalid accesses into
// APB SETUP/ACCESS transfers, handles wait states and aborts hung transfers.
module apb_initiator #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);

  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth:0] TimeoutVal = (CntWidth + 1)'(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e              state;
  logic [CntWidth-1:0] wait_cnt;
  logic [CntWidth:0]   wait_cnt_inc;
  logic                timeout_hit;
  logic                cnt_saturated;

  // Grant only from IDLE; reset qualifies req so nothing is accepted while held in reset.
  assign gnt_o = rst_ni & req_i & (state == IDLE);

  assign wait_cnt_inc  = {1'b0, wait_cnt} + (CntWidth + 1)'(1);
  assign cnt_saturated = (wait_cnt == {CntWidth{1'b1}});
  assign timeout_hit   = (TimeoutCycles != 0) && (wait_cnt_inc == TimeoutVal);

  // A completing pready in the last allowed ACCESS cycle takes priority over the abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pstrb_o   <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      rvalid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_o) begin
            paddr_o  <= addr_i;
            pwrite_o <= we_i;
            pwdata_o <= wdata_i;
            pstrb_o  <= we_i ? be_i : '0;
            psel_o   <= 1'b1;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            rdata_o   <= pwrite_o ? '0 : prdata_i;
            err_o     <= pslverr_i;
            rvalid_o  <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state     <= IDLE;
          end else if (timeout_hit) begin
            rdata_o   <= '0;
            err_o     <= 1'b1;
            rvalid_o  <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state     <= IDLE;
          end else if (!cnt_saturated) begin
            wait_cnt <= wait_cnt_inc[CntWidth-1:0];
          end
        end
        default: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  a_penable_needs_psel: assert property (@(posedge clk_i) disable iff (!rst_ni)
    penable_o |-> psel_o);

  a_no_grant_while_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    gnt_o |-> !psel_o);

  a_access_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (psel_o && penable_o) |-> $stable({paddr_o, pwdata_o, pstrb_o, pwrite_o}));

  a_single_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |=> !rvalid_o);

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: directed transfers push expected
// responses; a monitor pops and compares on every rvalid.
module tb_apb_initiator;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, we, rvalid, err, psel, penable, pwrite, pready, pslverr;
  logic [31:0] addr, wdata, rdata, paddr, pwdata, prdata;
  logic [3:0]  be, pstrb;

  logic        req_b, gnt_b, rvalid_b, err_b, psel_b, penable_b, pwrite_b;
  logic [31:0] rdata_b, paddr_b, pwdata_b;
  logic [3:0]  pstrb_b;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  resp_t exp_q[$];
  resp_t mon_r;

  // slave model controls and observations
  int          wait_states = 0;
  logic        hang = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_cnt = 0;
  int          last_acc_len = 0;
  logic        stable_ok = 1'b1;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_strb;
  logic        snap_write;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_initiator #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );

  apb_initiator #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(0)) dut_nt (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .psel_o(psel_b), .penable_o(penable_b), .pwrite_o(pwrite_b), .paddr_o(paddr_b),
    .pwdata_o(pwdata_b), .pstrb_o(pstrb_b), .prdata_i(prdata), .pready_i(1'b0),
    .pslverr_i(pslverr)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // APB slave: garbage outside ACCESS and on non-ready cycles so only the pready beat counts.
  always @(negedge clk) begin
    if (psel && !penable) begin
      snap_addr  = paddr;
      snap_wdata = pwdata;
      snap_strb  = pstrb;
      snap_write = pwrite;
      stable_ok  = 1'b1;
      acc_cnt    = 0;
      pready     = 1'b1;
      pslverr    = 1'b1;
      prdata     = 32'hA5A5_A5A5;
    end else if (psel && penable) begin
      if (paddr !== snap_addr || pwdata !== snap_wdata || pstrb !== snap_strb || pwrite !== snap_write)
        stable_ok = 1'b0;
      pready  = !hang && (acc_cnt == wait_states);
      pslverr = pready ? slv_err : 1'b1;
      prdata  = pready ? slv_rdata : ~slv_rdata;
      acc_cnt++;
    end else begin
      if (acc_cnt != 0) begin
        last_acc_len = acc_cnt;
        acc_cnt      = 0;
      end
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'hA5A5_A5A5;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected rvalid", 1, 0);
      end else begin
        mon_r = exp_q.pop_front();
        check_output("rdata", rdata, mon_r.rdata);
        check_output("err", err, mon_r.err);
        check_output("rvalid cycle", cyc, mon_r.cyc);
      end
    end
  end

  task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] b, input logic hold, input logic expect_resp,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int latency, output int gcyc);
    int guard = 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; be = b;
    #1;
    while (!gnt && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!gnt) begin
      check_output("grant timeout", 0, 1);
      req  = 1'b0;
      gcyc = -1;
      return;
    end
    gcyc = cyc;
    if (expect_resp) exp_q.push_back('{exp_rdata, exp_err, cyc + latency});
    @(negedge clk);
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_resp();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check_output("response timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   g1, g2;
    logic rv_seen;

    rst_n = 1'b0; req = 1'b1; req_b = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;
    #12;
    check_output("reset gnt", gnt, 0);
    check_output("reset psel", psel, 0);
    check_output("reset penable", penable, 0);
    check_output("reset rvalid", rvalid, 0);
    check_output("reset rdata/err", {rdata, err}, 0);
    check_output("reset paddr/pstrb/pwrite", {paddr, pstrb, pwrite}, 0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;

    $display("[TB] zero-wait write");
    wait_states = 0; hang = 1'b0; slv_err = 1'b0;
    apply_stimulus(1'b1, 32'h8, 32'h10, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0, 3, g1);
    #1;
    check_output("setup psel/penable", {psel, penable}, 2'b10);
    check_output("setup pwrite", pwrite, 1);
    check_output("setup paddr", paddr, 32'h8);
    check_output("setup pstrb", pstrb, 4'hF);
    check_output("setup pwdata", pwdata, 32'h10);
    @(negedge clk);
    #1;
    check_output("access psel/penable", {psel, penable}, 2'b11);
    wait_resp();
    check_output("write access length", last_acc_len, 1);

    $display("[TB] read with 2 wait states");
    wait_states = 2; slv_rdata = 32'hDEAD_BEEF;
    apply_stimulus(1'b0, 32'h0, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 5, g1);
    wait_resp();
    check_output("read access length", last_acc_len, 3);
    check_output("read stable", stable_ok, 1);
    check_output("read pstrb", snap_strb, 4'h0);

    $display("[TB] slave errors");
    wait_states = 1; slv_err = 1'b1; slv_rdata = 32'hCAFE_F00D;
    apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 4, g1);
    wait_resp();
    wait_states = 0;
    apply_stimulus(1'b1, 32'h44, 32'h0000_00FF, 4'h1, 1'b0, 1'b1, 32'h0, 1'b1, 3, g1);
    wait_resp();

    $display("[TB] timeout abort");
    hang = 1'b1; slv_err = 1'b0;
    apply_stimulus(1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b1, 6, g1);
    wait_resp();
    check_output("timeout access length", last_acc_len, 4);
    check_output("timeout psel dropped", {psel, penable}, 2'b00);

    $display("[TB] ready on last allowed access cycle");
    hang = 1'b0; wait_states = 3; slv_err = 1'b1; slv_rdata = 32'h1357_9BDF;
    apply_stimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1357_9BDF, 1'b1, 6, g1);
    wait_resp();
    check_output("late ready access length", last_acc_len, 4);
    slv_err = 1'b0;
    apply_stimulus(1'b1, 32'h24, 32'h5555_AAAA, 4'hC, 1'b0, 1'b1, 32'h0, 1'b0, 6, g1);
    wait_resp();

    $display("[TB] back-to-back");
    wait_states = 0; slv_rdata = 32'h2468_ACE0;
    apply_stimulus(1'b1, 32'h100, 32'hA5A5_0001, 4'h3, 1'b1, 1'b1, 32'h0, 1'b0, 3, g1);
    #1;
    check_output("b2b gnt in setup", gnt, 0);
    @(negedge clk);
    #1;
    check_output("b2b gnt in access", gnt, 0);
    apply_stimulus(1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 1'b1, 32'h2468_ACE0, 1'b0, 3, g2);
    check_output("b2b grant period", g2 - g1, 3);
    wait_resp();

    $display("[TB] reset during access");
    hang = 1'b1;
    apply_stimulus(1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 0, g1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset psel/penable/rvalid", {psel, penable, rvalid}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid) rv_seen = 1'b1;
    end
    check_output("no rvalid after reset", rv_seen, 0);
    slv_rdata = 32'h0F0F_1234;
    apply_stimulus(1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0F0F_1234, 1'b0, 3, g1);
    wait_resp();

    $display("[TB] timeout disabled, 1000 cycles of pready low");
    @(negedge clk);
    req_b = 1'b1;
    #1;
    check_output("no-timeout gnt", gnt_b, 1);
    @(negedge clk);
    req_b = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rvalid_b) rv_seen = 1'b1;
    end
    check_output("no-timeout rvalid", rv_seen, 0);
    check_output("no-timeout still in access", {psel_b, penable_b}, 2'b11);

    check_output("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
